piso_serializer: RTL and testbench

- Parallel-in, serial-out transmit shift register: the sending end of the serial bit-stream consumed by the team's serial-in/parallel-out capture registers.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock.
- Flags the first and last bit of each frame and supports gapless back-to-back words.
- Uses the same control set as the team's registers: synchronous clear, clock enable and asynchronous reset.

---
 rtl/piso_serializer.sv | 101 ++++++++++
 tb/tb_piso_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmit shifter with valid/ready load, frame flags
// and gapless back-to-back words; clear and enable mirror the capture registers.
module piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]  cnt, cnt_nx;
  logic           at_last;
  logic           xfer;
  logic [WIDTH-1:0] shifted;

  assign at_last    = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || at_last;
  assign xfer       = load_valid & load_ready & en & ~clr;

  // Zero-fill shift toward whichever end drives sout.
  always_comb begin
    if (MSB_FIRST != 0) shifted = {sreg[WIDTH-2:0], 1'b0};
    else                shifted = {1'b0, sreg[WIDTH-1:1]};
  end

  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    if (clr) begin
      state_nx = IDLE;
      sreg_nx  = '0;
      cnt_nx   = '0;
    end else if (en) begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            sreg_nx  = load_data;
            cnt_nx   = '0;
            state_nx = SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            sreg_nx = shifted;
            cnt_nx  = cnt + CW'(1);
          end else if (xfer) begin
            sreg_nx = load_data;
            cnt_nx  = '0;
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    sout = IDLE_LEVEL;
    if (state == SHIFT) begin
      if (MSB_FIRST != 0) sout = sreg[WIDTH-1];
      else                sout = sreg[0];
    end
  end

  assign sout_valid  = (state == SHIFT);
  assign frame_start = (state == SHIFT) && (cnt == '0);
  assign frame_last  = at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share clock and
// controls; expected frame bits are queued at load and popped on enabled bits.
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic first;
    logic last;
  } exp_t;

  logic       clk, reset, clr, en;
  logic       lv_m, lv_l;
  logic [7:0] ld_m, ld_l;
  logic       rdy_m, so_m, sv_m, fs_m, fl_m;
  logic       rdy_l, so_l, sv_l, fs_l, fl_l;

  exp_t q_m[$];
  exp_t q_l[$];
  int   total = 0;
  int   bad   = 0;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .reset(reset), .clr(clr), .en(en),
    .load_valid(lv_m), .load_data(ld_m), .load_ready(rdy_m),
    .sout(so_m), .sout_valid(sv_m), .frame_start(fs_m), .frame_last(fl_m)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .clr(clr), .en(en),
    .load_valid(lv_l), .load_data(ld_l), .load_ready(rdy_l),
    .sout(so_l), .sout_valid(sv_l), .frame_start(fs_l), .frame_last(fl_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic msb, input logic [7:0] data);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b     = msb ? data[7-i] : data[i];
      e.first = (i == 0);
      e.last  = (i == 7);
      if (msb) q_m.push_back(e);
      else     q_l.push_back(e);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_m_sout"},  {7'd0, so_m},  8'd0);
    check({tag, "_m_valid"}, {7'd0, sv_m},  8'd0);
    check({tag, "_m_flags"}, {6'd0, fs_m, fl_m}, 8'd0);
    check({tag, "_m_ready"}, {7'd0, rdy_m}, 8'd1);
    check({tag, "_l_valid"}, {7'd0, sv_l},  8'd0);
    check({tag, "_l_ready"}, {7'd0, rdy_l}, 8'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && (q_m.size() + q_l.size()) != 0; i++)
      @(negedge clk);
    check({tag, "_drain"}, 8'(q_m.size() + q_l.size()), 8'd0);
  endtask

  // Monitor: downstream consumes a bit only when en is high.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && en) begin
        if (sv_m) begin
          if (q_m.size() == 0) check("m_unexpected_bit", 8'd1, 8'd0);
          else begin
            e = q_m.pop_front();
            check("m_bit",   {7'd0, so_m}, {7'd0, e.b});
            check("m_start", {7'd0, fs_m}, {7'd0, e.first});
            check("m_last",  {7'd0, fl_m}, {7'd0, e.last});
          end
        end
        if (sv_l) begin
          if (q_l.size() == 0) check("l_unexpected_bit", 8'd1, 8'd0);
          else begin
            e = q_l.pop_front();
            check("l_bit",   {7'd0, so_l}, {7'd0, e.b});
            check("l_start", {7'd0, fs_l}, {7'd0, e.first});
            check("l_last",  {7'd0, fl_l}, {7'd0, e.last});
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1; clr = 1'b0; en = 1'b1;
    lv_m = 1'b0; lv_l = 1'b0; ld_m = '0; ld_l = '0;
    #2;
    idle_check("rst");
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_check("post_rst");
    end

    // Single MSB-first word 8'hA5.
    tick();
    lv_m = 1'b1; ld_m = 8'hA5; push_word(1'b1, 8'hA5);
    tick();
    lv_m = 1'b0;
    drain("a5");
    @(negedge clk);
    idle_check("a5_end");

    // LSB-first 8'h01 followed gaplessly by 8'hF0.
    tick();
    lv_l = 1'b1; ld_l = 8'h01; push_word(1'b0, 8'h01);
    tick();
    ld_l = 8'hF0; push_word(1'b0, 8'hF0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_ready0", {7'd0, rdy_l}, {7'd0, (k == 7)});
      check("b2b_valid0", {7'd0, sv_l}, 8'd1);
    end
    tick();
    lv_l = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("b2b_ready1", {7'd0, rdy_l}, {7'd0, (k == 7)});
      check("b2b_valid1", {7'd0, sv_l}, 8'd1);
    end
    @(negedge clk);
    idle_check("b2b_end");
    check("b2b_queue", 8'(q_l.size()), 8'd0);

    // Enable stall after bit 2 of 8'hC3.
    tick();
    lv_m = 1'b1; ld_m = 8'hC3; push_word(1'b1, 8'hC3);
    tick();
    lv_m = 1'b0;
    @(negedge clk);
    tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_sout",  {7'd0, so_m}, 8'd1);
      check("stall_valid", {7'd0, sv_m}, 8'd1);
    end
    tick();
    en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check("stall_last", {7'd0, fl_m}, {7'd0, (k == 6)});
    end
    @(negedge clk);
    idle_check("stall_end");
    check("stall_queue", 8'(q_m.size()), 8'd0);

    // Synchronous clear at bit 4 of 8'hFF with en low, then 8'h81.
    tick();
    lv_m = 1'b1; ld_m = 8'hFF; push_word(1'b1, 8'hFF);
    tick();
    lv_m = 1'b0;
    tick(); tick(); tick();
    clr = 1'b1; en = 1'b0;
    check("clr_consumed", 8'(q_m.size()), 8'd5);
    q_m.delete();
    @(negedge clk);
    check("clr_pending_valid", {7'd0, sv_m}, 8'd1);
    @(negedge clk);
    idle_check("clr");
    tick();
    clr = 1'b0; en = 1'b1;
    lv_m = 1'b1; ld_m = 8'h81; push_word(1'b1, 8'h81);
    tick();
    lv_m = 1'b0;
    drain("clr_81");
    @(negedge clk);
    idle_check("clr_81_end");

    // Asynchronous reset pulse inside bit 5 of 8'h3C, then 8'h96.
    tick();
    lv_m = 1'b1; ld_m = 8'h3C; push_word(1'b1, 8'h3C);
    tick();
    lv_m = 1'b0;
    tick(); tick(); tick(); tick();
    #1;
    reset = 1'b1;
    #1;
    idle_check("arst");
    check("arst_consumed", 8'(q_m.size()), 8'd4);
    q_m.delete();
    #8;
    reset = 1'b0;
    @(negedge clk);
    idle_check("arst_rel");
    tick();
    lv_m = 1'b1; ld_m = 8'h96; push_word(1'b1, 8'h96);
    tick();
    lv_m = 1'b0;
    drain("arst_96");
    @(negedge clk);
    idle_check("arst_96_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
